memory_arbiter: RTL and testbench

Shares one single-port, synchronous-read memory between the processor's instruction-fetch port and a load/store data port. Arbitrates with two-way round-robin, sequences each access through a small FSM and routes returned read data to the winning requester. Sits between the processor core and the program/data RAM.

---
 rtl/memory_pkg.sv | 10 +
 rtl/round_robin_picker.sv | 15 +
 rtl/memory_arbiter.sv | 100 ++++++++++
 tb/tb_memory_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared constants for the memory arbiter FSM, port ids and data widths.
package memory_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = 4;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ACCESS    = 2'd1;
    localparam logic [1:0] S_WAIT_READ = 2'd2;
    localparam logic k_port_fetch = 1'b0;
    localparam logic k_port_data  = 1'b1;
endpackage

// File: rtl/round_robin_picker.sv
// round_robin_picker: two-way round-robin choice; choice[0] = fetch, choice[1] = data.
module round_robin_picker
    import memory_pkg::*;
(
    input  logic       fetch_request,
    input  logic       data_request,
    input  logic       last_winner,
    output logic [1:0] choice
);
    logic pick_fetch;
    always_comb begin
        pick_fetch = fetch_request && (!data_request || last_winner == k_port_data);
        choice = {data_request && !pick_fetch, pick_fetch};
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one synchronous-read RAM between fetch and data ports.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  fetch_request,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_grant,
    output logic [DATA_WIDTH-1:0] fetch_read_data,
    output logic                  fetch_read_valid,
    input  logic                  data_request,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic                  data_write_enable,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    input  logic [MASK_WIDTH-1:0] data_write_mask,
    output logic                  data_grant,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  data_read_valid,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  memory_read_strobe,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    output logic [MASK_WIDTH-1:0] memory_write_mask,
    input  logic [DATA_WIDTH-1:0] memory_read_data
);
    logic [1:0]            state;
    logic                  last_winner;
    logic                  port;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [MASK_WIDTH-1:0] write_mask_q;
    logic [1:0]            choice;
    logic                  access;

    round_robin_picker picker (
        .fetch_request(fetch_request),
        .data_request (data_request),
        .last_winner  (last_winner),
        .choice       (choice)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            last_winner      <= k_port_data;
            port             <= k_port_fetch;
            write_q          <= 1'b0;
            address_q        <= '0;
            write_data_q     <= '0;
            write_mask_q     <= '0;
            fetch_read_data  <= '0;
            data_read_data   <= '0;
            fetch_read_valid <= 1'b0;
            data_read_valid  <= 1'b0;
        end else begin
            fetch_read_valid <= 1'b0;
            data_read_valid  <= 1'b0;
            if (state == S_IDLE) begin
                if (|choice) begin
                    state       <= S_ACCESS;
                    port        <= choice[1] ? k_port_data : k_port_fetch;
                    last_winner <= choice[1] ? k_port_data : k_port_fetch;
                    address_q   <= choice[1] ? data_address : fetch_address;
                    write_q     <= choice[1] && data_write_enable;
                    // Write fields only change on a data win so memory_write_data keeps its last value.
                    if (choice[1]) begin
                        write_data_q <= data_write_data;
                        write_mask_q <= data_write_mask;
                    end
                end
            end else if (state == S_ACCESS) begin
                state <= write_q ? S_IDLE : S_WAIT_READ;
            end else if (state == S_WAIT_READ) begin
                state <= S_IDLE;
                if (port == k_port_fetch) begin
                    fetch_read_data  <= memory_read_data;
                    fetch_read_valid <= 1'b1;
                end else begin
                    data_read_data  <= memory_read_data;
                    data_read_valid <= 1'b1;
                end
            end else begin
                state <= S_IDLE;
            end
        end
    end

    always_comb begin
        access             = state == S_ACCESS;
        fetch_grant        = access && port == k_port_fetch;
        data_grant         = access && port == k_port_data;
        memory_address     = address_q;
        memory_write_data  = write_data_q;
        memory_read_strobe = access && !write_q;
        memory_write_mask  = (access && write_q) ? write_mask_q : '0;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench with a behavioural RAM and round-robin reference model.
module tb_memory_arbiter;
    import memory_pkg::*;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_request = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        fetch_grant;
    logic [31:0] fetch_read_data;
    logic        fetch_read_valid;
    logic        data_request = 1'b0;
    logic [31:0] data_address = '0;
    logic        data_write_enable = 1'b0;
    logic [31:0] data_write_data = '0;
    logic [3:0]  data_write_mask = '0;
    logic        data_grant;
    logic [31:0] data_read_data;
    logic        data_read_valid;
    logic [31:0] memory_address;
    logic        memory_read_strobe;
    logic [31:0] memory_write_data;
    logic [3:0]  memory_write_mask;
    logic [31:0] memory_read_data = '0;

    memory_arbiter #(.ADDR_WIDTH(32)) dut (
        .CLK(CLK), .reset(reset),
        .fetch_request(fetch_request), .fetch_address(fetch_address),
        .fetch_grant(fetch_grant), .fetch_read_data(fetch_read_data),
        .fetch_read_valid(fetch_read_valid),
        .data_request(data_request), .data_address(data_address),
        .data_write_enable(data_write_enable), .data_write_data(data_write_data),
        .data_write_mask(data_write_mask), .data_grant(data_grant),
        .data_read_data(data_read_data), .data_read_valid(data_read_valid),
        .memory_address(memory_address), .memory_read_strobe(memory_read_strobe),
        .memory_write_data(memory_write_data), .memory_write_mask(memory_write_mask),
        .memory_read_data(memory_read_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        fq[$];
    exp_t        dq[$];
    logic [31:0] ram[256];
    logic [31:0] ref_mem[256];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        pf = 1'b0, pd = 1'b0, tb_last = 1'b1;
    logic        last_fg = 1'b0, last_dg = 1'b0;
    int          fwait = 0, dwait = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return i == 16 ? 32'hDEAD_BEEF : i == 32 ? 32'hFFFF_FFFF : {b, b ^ 8'hA5, ~b, b + 8'd3};
    endfunction

    // Behavioural RAM: registered read, byte-masked write, reloaded while reset is high.
    always @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            if (memory_read_strobe) memory_read_data <= ram[memory_address[7:0]];
            for (int b = 0; b < 4; b++)
                if (memory_write_mask[b]) ram[memory_address[7:0]][8*b+:8] <= memory_write_data[8*b+:8];
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic issue_f(input logic [31:0] a);
        fetch_request = 1'b1;
        fetch_address = a;
        fwait = 0;
        pf = 1'b1;
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        data_request = 1'b1;
        data_address = a;
        data_write_enable = we;
        data_write_data = wd;
        data_write_mask = m;
        dwait = 0;
        pd = 1'b1;
    endtask

    // One clock of the requester/reference model; pf/pd hold what the DUT sampled last edge.
    task automatic cycle(input int p_f, input int p_d, input int p_w, input int amax);
        logic fg, dg, ef, ed;
        @(negedge CLK);
        fg = fetch_grant;
        dg = data_grant;
        last_fg = fg;
        last_dg = dg;
        if (fg || dg) begin
            ef = pf && (!pd || tb_last == 1'b1);
            ed = pd && !ef;
            chk("grant_choice", {62'd0, fg, dg}, {62'd0, ef, ed});
            if (fg) begin
                chk("fetch_access", {27'd0, memory_address, memory_read_strobe, memory_write_mask},
                    {27'd0, fetch_address, 1'b1, 4'b0000});
                fq.push_back('{ref_mem[fetch_address[7:0]], cyc + 2});
                fetch_request = 1'b0;
                tb_last = 1'b0;
                fwait = 0;
            end else begin
                chk("data_address", {32'd0, memory_address}, {32'd0, data_address});
                if (data_write_enable) begin
                    chk("write_ctrl", {59'd0, memory_read_strobe, memory_write_mask},
                        {59'd0, 1'b0, data_write_mask});
                    chk("write_data", {32'd0, memory_write_data}, {32'd0, data_write_data});
                    for (int b = 0; b < 4; b++)
                        if (data_write_mask[b]) ref_mem[data_address[7:0]][8*b+:8] = data_write_data[8*b+:8];
                end else begin
                    chk("read_ctrl", {59'd0, memory_read_strobe, memory_write_mask}, {59'd0, 1'b1, 4'b0000});
                    dq.push_back('{ref_mem[data_address[7:0]], cyc + 2});
                end
                data_request = 1'b0;
                tb_last = 1'b1;
                dwait = 0;
            end
        end
        if (fetch_request && !fg && ++fwait > 10) begin
            fail("fetch_timeout");
            fetch_request = 1'b0;
        end
        if (data_request && !dg && ++dwait > 10) begin
            fail("data_timeout");
            data_request = 1'b0;
        end
        if (!fetch_request && $urandom_range(99) < p_f)
            issue_f($urandom_range(amax));
        if (!data_request && $urandom_range(99) < p_d)
            issue_d($urandom_range(99) < p_w, $urandom_range(amax), $urandom, 4'($urandom_range(15)));
        pf = fetch_request;
        pd = data_request;
    endtask

    // Monitor: pops expected read data on each valid pulse, checks hold and idle strobes.
    initial begin : monitor
        logic [31:0] lf, ld;
        exp_t e;
        lf = '0;
        ld = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                lf = fetch_read_data;
                ld = data_read_data;
            end else begin
                if (fetch_read_valid) begin
                    if (fq.size() == 0) fail("fetch_spurious_valid");
                    else begin
                        e = fq.pop_front();
                        chk("fetch_rdata", {32'd0, fetch_read_data}, {32'd0, e.data});
                        chk("fetch_latency", 64'(cyc), 64'(e.due));
                    end
                    lf = fetch_read_data;
                end else chk("fetch_hold", {32'd0, fetch_read_data}, {32'd0, lf});
                if (data_read_valid) begin
                    if (dq.size() == 0) fail("data_spurious_valid");
                    else begin
                        e = dq.pop_front();
                        chk("data_rdata", {32'd0, data_read_data}, {32'd0, e.data});
                        chk("data_latency", 64'(cyc), 64'(e.due));
                    end
                    ld = data_read_data;
                end else chk("data_hold", {32'd0, data_read_data}, {32'd0, ld});
                if (!fetch_grant && !data_grant)
                    chk("idle_strobe_mask", {59'd0, memory_read_strobe, memory_write_mask}, 64'd0);
            end
        end
    end

    initial begin : driver
        int n;
        ref_init();
        repeat (3) @(negedge CLK);
        chk("reset_ctrl", {58'd0, fetch_grant, data_grant, fetch_read_valid, data_read_valid,
            memory_read_strobe, |memory_write_mask}, 64'd0);
        chk("reset_rdata", {fetch_read_data, data_read_data}, 64'd0);
        chk("reset_mem_out", {memory_address, memory_write_data}, 64'd0);
        reset = 1'b0;
        // Fetch read of a preloaded word: grant next cycle, data two cycles after grant.
        issue_f(32'h10);
        cycle(0, 0, 0, 0);
        chk("first_fetch_grant", {63'd0, last_fg}, 64'd1);
        repeat (3) cycle(0, 0, 0, 0);
        // Masked write then read-back of the same word.
        issue_d(1'b1, 32'h20, 32'h1122_3344, 4'b0101);
        cycle(0, 0, 0, 0);
        chk("write_grant", {63'd0, last_dg}, 64'd1);
        cycle(0, 0, 0, 0);
        issue_d(1'b0, 32'h20, '0, '0);
        repeat (4) cycle(0, 0, 0, 0);
        // Empty-mask write leaves the word alone.
        issue_d(1'b1, 32'h30, 32'hCAFE_F00D, 4'b0000);
        repeat (2) cycle(0, 0, 0, 0);
        issue_d(1'b0, 32'h30, '0, '0);
        repeat (4) cycle(0, 0, 0, 0);
        // Data read followed by a fetch read: data_read_data must hold.
        issue_d(1'b0, 32'h5, '0, '0);
        repeat (4) cycle(0, 0, 0, 0);
        issue_f(32'h6);
        repeat (4) cycle(0, 0, 0, 0);
        // Reset during WAIT_READ kills the in-flight read.
        issue_f(32'h10);
        cycle(0, 0, 0, 0);
        @(negedge CLK);
        #2 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {58'd0, fetch_grant, data_grant, fetch_read_valid, data_read_valid,
            memory_read_strobe, |memory_write_mask}, 64'd0);
        chk("midreset_rdata", {fetch_read_data, data_read_data}, 64'd0);
        chk("midreset_mem_out", {memory_address, memory_write_data}, 64'd0);
        fq.delete();
        dq.delete();
        tb_last = 1'b1;
        ref_init();
        fetch_request = 1'b0;
        data_request = 1'b0;
        repeat (2) @(negedge CLK);
        issue_f(32'h11);
        issue_d(1'b0, 32'h12, '0, '0);
        #2 reset = 1'b0;
        // Sustained contention: grants interleave starting with fetch.
        cycle(100, 100, 0, 63);
        chk("tie_after_reset", {62'd0, last_fg, last_dg}, 64'd2);
        repeat (13) cycle(100, 100, 0, 63);
        // Random traffic.
        repeat (400) cycle(40, 40, 40, 63);
        n = 0;
        while ((fq.size() != 0 || dq.size() != 0 || fetch_request || data_request) && n < 30) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        @(negedge CLK);
        chk("queues_drained", 64'(fq.size() + dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
